// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types for the MEM stage: FSM states and the EX/MEM record.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int DEPTH_DEFAULT = 256;
    localparam int ADDR_W        = $clog2(DEPTH_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic        branch;
        logic        zero;
        logic [63:0] pcbranch;
        logic [63:0] result;
        logic [63:0] wdata;
    } ex_mem_t;

    // Doubleword accesses must be 8-byte aligned; non-memory ops never are misaligned.
    function automatic logic is_misaligned(input ex_mem_t op);
        return (op.mem_read || op.mem_write) && (op.result[2:0] != 3'b000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_bank.sv
// ============================================================================
// Module : data_mem_bank
// Brief  : Single-port synchronous 64-bit data memory, read-before-write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_bank #(
    parameter int DEPTH  = pipe_pkg::DEPTH_DEFAULT,
    parameter int ADDR_W = pipe_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    output logic [63:0]       o_rdata
);

    logic [63:0] r_mem [DEPTH];

    // Array is deliberately not reset so its contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : RISC-V MEM stage: EX/MEM register, multi-cycle data memory access,
//          branch resolution and registered writeback outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        regWrite_receive,
    input  logic        Mem_to_Reg_receive,
    input  logic        Mem_Write_receive,
    input  logic        Mem_Read_receive,
    input  logic        Branch_receive,
    input  logic        Zero_receive,
    input  logic [63:0] pcbranch_receive,
    input  logic [63:0] Result_receive,
    input  logic [63:0] read_data_2_receive,
    output logic        stall,
    output logic        out_valid,
    output logic        regWrite,
    output logic        Mem_to_Reg,
    output logic [63:0] read_data,
    output logic [63:0] alu_result,
    output logic        pc_src,
    output logic [63:0] pc_branch,
    output logic        misaligned
);

    localparam int         c_ADDR_W   = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = 4'(MEM_LATENCY - 1);

    mem_state_t  r_state, w_next_state;
    logic [3:0]  r_cnt, w_next_cnt;
    ex_mem_t     r_ex, w_in, w_src;
    logic        w_capture, w_mem_en, w_load_out;
    logic [63:0] w_mem_rdata;

    logic        r_taken, r_mis, r_is_load;

    assign w_in = '{
        reg_write:  regWrite_receive,
        mem_to_reg: Mem_to_Reg_receive,
        mem_write:  Mem_Write_receive,
        mem_read:   Mem_Read_receive,
        branch:     Branch_receive,
        zero:       Zero_receive,
        pcbranch:   pcbranch_receive,
        result:     Result_receive,
        wdata:      read_data_2_receive
    };

    assign stall     = (r_state == ST_ACCESS);
    assign w_capture = in_valid && !stall;
    // Results come straight from the inputs on a one-cycle op, from the EX/MEM register after an access.
    assign w_src     = (r_state == ST_ACCESS) ? r_ex : w_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_mem_en     = 1'b0;
        w_load_out   = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_next_state = ST_IDLE;
                if (in_valid) begin
                    if ((w_in.mem_read || w_in.mem_write) && !is_misaligned(w_in)) begin
                        w_next_state = ST_ACCESS;
                        w_next_cnt   = c_CNT_INIT;
                    end else begin
                        w_next_state = ST_RESP;
                        w_load_out   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_mem_en     = 1'b1;
                    w_load_out   = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (w_capture) begin
            r_ex <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite   <= 1'b0;
            Mem_to_Reg <= 1'b0;
            alu_result <= 64'd0;
            pc_branch  <= 64'd0;
            r_taken    <= 1'b0;
            r_mis      <= 1'b0;
            r_is_load  <= 1'b0;
        end else if (w_load_out) begin
            regWrite   <= w_src.reg_write && !is_misaligned(w_src);
            Mem_to_Reg <= w_src.mem_to_reg;
            alu_result <= w_src.result;
            pc_branch  <= w_src.pcbranch;
            r_taken    <= w_src.branch && w_src.zero;
            r_mis      <= is_misaligned(w_src);
            r_is_load  <= w_src.mem_read && !is_misaligned(w_src);
        end
    end

    data_mem_bank #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (r_ex.mem_write),
        .i_addr  (r_ex.result[3 +: c_ADDR_W]),
        .i_wdata (r_ex.wdata),
        .o_rdata (w_mem_rdata)
    );

    // Memory output only changes on an access, so it holds between pulses like the other outputs.
    assign out_valid  = (r_state == ST_RESP);
    assign read_data  = r_is_load ? w_mem_rdata : 64'd0;
    assign pc_src     = out_valid && r_taken;
    assign misaligned = out_valid && r_mis;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Scoreboard testbench for mem_access_stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    localparam int c_DEPTH = 256;
    localparam int c_LAT   = 2;

    logic        clk, rst_n, in_valid;
    logic        regWrite_receive, Mem_to_Reg_receive, Mem_Write_receive, Mem_Read_receive;
    logic        Branch_receive, Zero_receive;
    logic [63:0] pcbranch_receive, Result_receive, read_data_2_receive;
    logic        stall, out_valid, regWrite, Mem_to_Reg, pc_src, misaligned;
    logic [63:0] read_data, alu_result, pc_branch;

    mem_access_stage #(.DEPTH(c_DEPTH), .MEM_LATENCY(c_LAT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .regWrite_receive    (regWrite_receive),
        .Mem_to_Reg_receive  (Mem_to_Reg_receive),
        .Mem_Write_receive   (Mem_Write_receive),
        .Mem_Read_receive    (Mem_Read_receive),
        .Branch_receive      (Branch_receive),
        .Zero_receive        (Zero_receive),
        .pcbranch_receive    (pcbranch_receive),
        .Result_receive      (Result_receive),
        .read_data_2_receive (read_data_2_receive),
        .stall               (stall),
        .out_valid           (out_valid),
        .regWrite            (regWrite),
        .Mem_to_Reg          (Mem_to_Reg),
        .read_data           (read_data),
        .alu_result          (alu_result),
        .pc_src              (pc_src),
        .pc_branch           (pc_branch),
        .misaligned          (misaligned)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [63:0] rd;
        logic [63:0] alu;
        logic        pcs;
        logic [63:0] pcb;
        logic        mis;
        int          lat;
        int          stl;
        int          cap;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   stall_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected record per out_valid pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("regWrite",   {63'd0, regWrite},   {63'd0, e.rw});
                chk("Mem_to_Reg", {63'd0, Mem_to_Reg}, {63'd0, e.m2r});
                chk("read_data",  read_data,           e.rd);
                chk("alu_result", alu_result,          e.alu);
                chk("pc_src",     {63'd0, pc_src},     {63'd0, e.pcs});
                chk("pc_branch",  pc_branch,           e.pcb);
                chk("misaligned", {63'd0, misaligned}, {63'd0, e.mis});
                chk("latency",    64'(cyc - e.cap + 1), 64'(e.lat));
                chk("stall_cycles", 64'(stall_cnt),    64'(e.stl));
            end
            stall_cnt = 0;
        end else if (stall) begin
            stall_cnt++;
        end
    end

    task automatic send(input logic rw, input logic m2r, input logic mw, input logic mr,
                        input logic br, input logic z, input logic [63:0] pcb,
                        input logic [63:0] res, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input bit push);
        int   n;
        exp_t e;
        logic mis, mem;
        @(negedge clk);
        regWrite_receive    = rw;
        Mem_to_Reg_receive  = m2r;
        Mem_Write_receive   = mw;
        Mem_Read_receive    = mr;
        Branch_receive      = br;
        Zero_receive        = z;
        pcbranch_receive    = pcb;
        Result_receive      = res;
        read_data_2_receive = wd;
        in_valid            = 1'b1;
        n = 0;
        while (stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            checks++;
            failures++;
            $display("FAIL stall_timeout actual=1 required=0");
        end
        mis = (mr || mw) && (res[2:0] != 3'b000);
        mem = (mr || mw) && !mis;
        if (push) begin
            e.rw  = rw && !mis;
            e.m2r = m2r;
            e.rd  = exp_rd;
            e.alu = res;
            e.pcs = br && z;
            e.pcb = pcb;
            e.mis = mis;
            e.lat = mem ? c_LAT + 1 : 1;
            e.stl = mem ? c_LAT : 0;
            e.cap = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_stall"},      {63'd0, stall},      64'd0);
        chk({tag, "_out_valid"},  {63'd0, out_valid},  64'd0);
        chk({tag, "_regWrite"},   {63'd0, regWrite},   64'd0);
        chk({tag, "_Mem_to_Reg"}, {63'd0, Mem_to_Reg}, 64'd0);
        chk({tag, "_read_data"},  read_data,           64'd0);
        chk({tag, "_alu_result"}, alu_result,          64'd0);
        chk({tag, "_pc_src"},     {63'd0, pc_src},     64'd0);
        chk({tag, "_pc_branch"},  pc_branch,           64'd0);
        chk({tag, "_misaligned"}, {63'd0, misaligned}, 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        in_valid = 1'b0;
        {regWrite_receive, Mem_to_Reg_receive, Mem_Write_receive, Mem_Read_receive} = 4'b0;
        {Branch_receive, Zero_receive} = 2'b0;
        pcbranch_receive = 64'd0;
        Result_receive = 64'd0;
        read_data_2_receive = 64'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        //   rw m2r mw mr br z  pcbranch   result      wdata          exp read_data
        send(1, 0, 0, 0, 0, 0, 64'h0,     64'h2A,     64'h0,         64'h0,        1);
        send(0, 0, 1, 0, 0, 0, 64'h0,     64'h10,     64'hDEADBEEF,  64'h0,        1);
        send(1, 1, 0, 1, 0, 0, 64'h0,     64'h10,     64'h0,         64'hDEADBEEF, 1);
        send(0, 0, 0, 0, 1, 1, 64'h400,   64'h0,      64'h0,         64'h0,        1);
        send(0, 0, 0, 0, 1, 0, 64'h400,   64'h5,      64'h0,         64'h0,        1);
        send(1, 1, 0, 1, 0, 0, 64'h0,     64'h13,     64'h0,         64'h0,        1);
        // Back-to-back single-cycle ops.
        send(1, 0, 0, 0, 0, 0, 64'h0,     64'h1111,   64'h0,         64'h0,        1);
        send(1, 0, 0, 0, 0, 0, 64'h0,     64'h2222,   64'h0,         64'h0,        1);
        // Wrap: DEPTH*8 aliases address 0; the ALU op waits out the load's stall.
        send(0, 0, 1, 0, 0, 0, 64'h0,     64'h0,      64'h1234,      64'h0,        1);
        send(1, 1, 0, 1, 0, 0, 64'h0,     64'h800,    64'h0,         64'h1234,     1);
        send(1, 0, 0, 0, 0, 0, 64'h0,     64'h77,     64'h0,         64'h0,        1);
        // Read and write together: old contents returned, new ones stored.
        send(1, 1, 1, 1, 0, 0, 64'h0,     64'h10,     64'h99,        64'hDEADBEEF, 1);
        send(1, 1, 0, 1, 0, 0, 64'h0,     64'h10,     64'h0,         64'h99,       1);
        // Reset during a store's access abandons the write.
        send(0, 0, 1, 0, 0, 0, 64'h0,     64'h8,      64'h55,        64'h0,        1);
        send(0, 0, 1, 0, 0, 0, 64'h0,     64'h8,      64'hFF,        64'h0,        0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 1, 0, 1, 0, 0, 64'h0,     64'h8,      64'h0,         64'h55,       1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
